// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and helpers for the Johnson phase decoder
package johnson_pkg;
   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
   localparam logic [7:0] ERR_MAX = 8'hFF;
   function automatic int phase_width(input int width);
      return $clog2(2 * width);
   endfunction
endpackage

// File: rtl/johnson_phase_decoder_if.sv
// johnson_phase_decoder_if: sample input and decoded status bundle
interface johnson_phase_decoder_if import johnson_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int CYC_W = 8
);
   localparam int PH_W = phase_width(WIDTH);
   logic             in_valid;
   logic [WIDTH-1:0] johnson_in;
   logic             out_valid;
   logic [PH_W-1:0]  phase;
   logic             legal;
   logic             seq_err;
   logic             locked;
   logic [CYC_W-1:0] wrap_cnt;
   logic [7:0]       err_cnt;
   modport master (output in_valid, johnson_in,
                   input  out_valid, phase, legal, seq_err, locked, wrap_cnt, err_cnt);
   modport slave  (input  in_valid, johnson_in,
                   output out_valid, phase, legal, seq_err, locked, wrap_cnt, err_cnt);
endinterface

// File: rtl/johnson_code_check.sv
// johnson_code_check: classifies a Johnson code and maps it to its phase index
module johnson_code_check import johnson_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int PH_W  = phase_width(WIDTH)
) (
   input  logic [WIDTH-1:0] code,
   output logic             legal,
   output logic [PH_W-1:0]  phase
);
   localparam logic [WIDTH-1:0] ONES = '1;
   always_comb begin
      legal = 1'b0;
      phase = '0;
      for (int k = 0; k <= WIDTH; k++)
         if (code == (ONES >> (WIDTH - k))) begin
            legal = 1'b1;
            phase = PH_W'(k);
         end
      // filling from the top: j low zeros under WIDTH-j ones
      for (int j = 1; j < WIDTH; j++)
         if (code == (ONES << j)) begin
            legal = 1'b1;
            phase = PH_W'(WIDTH + j);
         end
   end
endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: checks Johnson sequence order, tracks lock, wraps and errors
module johnson_phase_decoder import johnson_pkg::*; #(
   parameter int WIDTH  = 8,
   parameter int PH_W   = phase_width(WIDTH),
   parameter int CYC_W  = 8,
   parameter int LOCK_N = 4
) (
   input logic clk,
   input logic rst,
   johnson_phase_decoder_if.slave bus
);
   localparam int MW = $clog2(LOCK_N + 1);
   localparam logic [PH_W-1:0] LAST = PH_W'(2 * WIDTH - 1);
   logic             chk_legal;
   logic [PH_W-1:0]  chk_phase;
   logic             out_valid_q, out_valid_d, legal_q, legal_d, seq_err_q, seq_err_d;
   logic             prev_valid_q, prev_valid_d;
   logic [PH_W-1:0]  phase_q, phase_d, prev_phase_q, prev_phase_d, next_ph;
   logic [MW-1:0]    match_q, match_d;
   logic [CYC_W-1:0] wrap_q, wrap_d;
   logic [7:0]       err_q, err_d;
   logic             stall, adv, err;
   lock_state_e      state_q, state_d;
   johnson_code_check #(.WIDTH(WIDTH), .PH_W(PH_W)) u_chk (
      .code (bus.johnson_in),
      .legal(chk_legal),
      .phase(chk_phase)
   );
   always_comb begin
      next_ph      = prev_phase_q == LAST ? '0 : prev_phase_q + 1'b1;
      stall        = bus.in_valid && prev_valid_q && chk_legal && chk_phase == prev_phase_q;
      adv          = bus.in_valid && prev_valid_q && chk_legal && chk_phase == next_ph;
      err          = bus.in_valid && (!chk_legal || (prev_valid_q && !stall && !adv));
      out_valid_d  = bus.in_valid;
      seq_err_d    = err;
      phase_d      = bus.in_valid ? chk_phase : phase_q;
      legal_d      = bus.in_valid ? chk_legal : legal_q;
      prev_valid_d = bus.in_valid ? chk_legal : prev_valid_q;
      prev_phase_d = bus.in_valid && chk_legal ? chk_phase : prev_phase_q;
      wrap_d       = adv && prev_phase_q == LAST ? wrap_q + 1'b1 : wrap_q;
      err_d        = err && err_q != ERR_MAX ? err_q + 8'd1 : err_q;
      // match count saturates at LOCK_N so it cannot roll over while locked
      match_d      = err ? '0 : adv && match_q != MW'(LOCK_N) ? match_q + 1'b1 : match_q;
      state_d      = err ? UNLOCKED : match_d == MW'(LOCK_N) ? LOCKED : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         seq_err_q    <= 1'b0;
         phase_q      <= '0;
         legal_q      <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_phase_q <= '0;
         wrap_q       <= '0;
         err_q        <= '0;
         match_q      <= '0;
         state_q      <= UNLOCKED;
      end else begin
         out_valid_q  <= out_valid_d;
         seq_err_q    <= seq_err_d;
         phase_q      <= phase_d;
         legal_q      <= legal_d;
         prev_valid_q <= prev_valid_d;
         prev_phase_q <= prev_phase_d;
         wrap_q       <= wrap_d;
         err_q        <= err_d;
         match_q      <= match_d;
         state_q      <= state_d;
      end
   end
   assign bus.out_valid = out_valid_q;
   assign bus.phase     = phase_q;
   assign bus.legal     = legal_q;
   assign bus.seq_err   = seq_err_q;
   assign bus.locked    = state_q == LOCKED;
   assign bus.wrap_cnt  = wrap_q;
   assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb_johnson_phase_decoder: directed vector table plus saturation and reset sequences
module tb_johnson_phase_decoder;
   typedef struct {
      logic       v;
      logic [7:0] code;
      logic [3:0] ph;
      logic       lg, se, lk;
      logic [7:0] wr, ec;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tv[$];
   johnson_phase_decoder_if #(.WIDTH(8), .CYC_W(8)) bus ();
   johnson_phase_decoder #(.WIDTH(8), .PH_W(4), .CYC_W(8), .LOCK_N(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step(input logic v, input logic [7:0] code);
      bus.in_valid   = v;
      bus.johnson_in = code;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_all(input string nm, input vec_t e);
      chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(e.v));
      chk({nm, " phase"},     32'(bus.phase),     32'(e.ph));
      chk({nm, " legal"},     32'(bus.legal),     32'(e.lg));
      chk({nm, " seq_err"},   32'(bus.seq_err),   32'(e.se));
      chk({nm, " locked"},    32'(bus.locked),    32'(e.lk));
      chk({nm, " wrap_cnt"},  32'(bus.wrap_cnt),  32'(e.wr));
      chk({nm, " err_cnt"},   32'(bus.err_cnt),   32'(e.ec));
   endtask
   initial begin
      int ec;
      // clean run 0..15 then 0
      tv.push_back('{1, 8'h00, 0, 1, 0, 0, 0, 0});
      tv.push_back('{1, 8'h01, 1, 1, 0, 0, 0, 0});
      tv.push_back('{1, 8'h03, 2, 1, 0, 0, 0, 0});
      tv.push_back('{1, 8'h07, 3, 1, 0, 0, 0, 0});
      tv.push_back('{1, 8'h0F, 4, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'h1F, 5, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'h3F, 6, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'h7F, 7, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hFF, 8, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hFE, 9, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hFC, 10, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hF8, 11, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hF0, 12, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hE0, 13, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'hC0, 14, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'h80, 15, 1, 0, 1, 0, 0});
      tv.push_back('{1, 8'h00, 0, 1, 0, 1, 1, 0});
      // advance to 0x07 then stall there
      tv.push_back('{1, 8'h01, 1, 1, 0, 1, 1, 0});
      tv.push_back('{1, 8'h03, 2, 1, 0, 1, 1, 0});
      for (int i = 0; i < 5; i++) tv.push_back('{1, 8'h07, 3, 1, 0, 1, 1, 0});
      // illegal code while locked, then a fresh first sample
      tv.push_back('{1, 8'h05, 0, 0, 1, 0, 1, 1});
      tv.push_back('{1, 8'h0F, 4, 1, 0, 0, 1, 1});
      tv.push_back('{1, 8'h1F, 5, 1, 0, 0, 1, 1});
      tv.push_back('{1, 8'h3F, 6, 1, 0, 0, 1, 1});
      tv.push_back('{1, 8'h7F, 7, 1, 0, 0, 1, 1});
      tv.push_back('{1, 8'hFF, 8, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hFE, 9, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hFC, 10, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hF8, 11, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hF0, 12, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hE0, 13, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'hC0, 14, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'h80, 15, 1, 0, 1, 1, 1});
      tv.push_back('{1, 8'h00, 0, 1, 0, 1, 2, 1});
      tv.push_back('{1, 8'h01, 1, 1, 0, 1, 2, 1});
      tv.push_back('{1, 8'h03, 2, 1, 0, 1, 2, 1});
      // skipped phase 2 -> 4
      tv.push_back('{1, 8'h0F, 4, 1, 1, 0, 2, 2});
      tv.push_back('{1, 8'h1F, 5, 1, 0, 0, 2, 2});
      // idle cycle holds everything
      tv.push_back('{0, 8'h55, 5, 1, 0, 0, 2, 2});
      bus.in_valid   = 1'b1;
      bus.johnson_in = 8'h0F;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'h00);
      chk_all("reset", '{0, 8'h00, 0, 0, 0, 0, 0, 0});
      foreach (tv[i]) begin
         step(tv[i].v, tv[i].code);
         chk_all($sformatf("vec%0d", i), tv[i]);
      end
      ec = 2;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, i % 2 ? 8'h5A : 8'h05);
         ec = ec < 255 ? ec + 1 : 255;
         chk($sformatf("sat%0d err_cnt", i), 32'(bus.err_cnt), 32'(ec));
         chk($sformatf("sat%0d seq_err", i), 32'(bus.seq_err), 32'd1);
      end
      rst = 1'b1;
      step(1'b1, 8'h07);
      chk_all("midreset", '{0, 8'h00, 0, 0, 0, 0, 0, 0});
      rst = 1'b0;
      step(1'b1, 8'h0F);
      chk_all("post_reset first", '{1, 8'h0F, 4, 1, 0, 0, 0, 0});
      step(1'b1, 8'h1F);
      chk_all("post_reset adv", '{1, 8'h1F, 5, 1, 0, 0, 0, 0});
      step(1'b1, 8'h7F);
      chk_all("post_reset skip", '{1, 8'h7F, 7, 1, 1, 0, 0, 1});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Sits directly downstream of the Johnson counter core, on its parallel state output.
- Checks every sampled code for legality and decodes it to a binary phase index.
- Confirms that successive samples follow the Johnson sequence, and keeps a lock flag, a wrap counter and an error counter for the top-level outputs.
- Fully synchronous, single clock domain.

Parameters:
- WIDTH, 8, Johnson register width; sequence length is 2*WIDTH states.
- PH_W, $clog2(2*WIDTH), phase index width (4 for WIDTH=8).
- CYC_W, 8, wrap counter width.
- LOCK_N, 4, consecutive valid successors required to assert lock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  johnson_in is sampled this cycle.
- johnson_in  input  WIDTH  Johnson counter state.
- out_valid  output  1  registered copy of in_valid.
- phase  output  PH_W  decoded phase of the last sample.
- legal  output  1  last sample was a legal Johnson code.
- seq_err  output  1  one-cycle pulse on an illegal code or a bad successor.
- locked  output  1  lock state machine is in LOCKED.
- wrap_cnt  output  CYC_W  count of completed full sequences.
- err_cnt  output  8  saturating count of seq_err pulses.

Behaviour:
- Reset (rst high at a clk edge) clears all state; overrides all other inputs.
  - All outputs go to 0; FSM goes to UNLOCKED; match counter goes to 0.
  - prev_valid clears, so the first sample after reset has no predecessor.
- Reset mid-stream discards history; the next sample is treated as the first.
- Legal codes:
  - Low-side form, low k bits set (0 ≤ k ≤ WIDTH): phase = k.
  - High-side form, top WIDTH−j bits set over j low zeros (1 ≤ j ≤ WIDTH−1): phase = WIDTH + j.
  - Any other code is illegal: legal=0, phase=0.
- Latency: all outputs are registered, one cycle after the in_valid sample.
- When in_valid=0: out_valid=0, seq_err=0; phase, legal, locked and counters hold.
- Successor rule, for a legal sample when prev_valid=1:
  - OK if phase == prev_phase (counter stalled) or phase == (prev_phase+1) mod 2*WIDTH.
  - Anything else is BAD.
  - First legal sample after reset or after an illegal code: stores prev_phase and sets prev_valid; never BAD.
- seq_err=1 for exactly one cycle on an illegal code or a BAD successor.
  - An illegal code also clears prev_valid.
- FSM states UNLOCKED and LOCKED:
  - Match counter increments on each OK advance (phase changed).
  - A stall holds the match counter.
  - An error clears the match counter.
  - UNLOCKED → LOCKED when the match counter reaches LOCK_N.
  - LOCKED → UNLOCKED on any seq_err.
  - An error and a transition in the same cycle: the error wins.
- wrap_cnt increments on an OK advance from phase 2*WIDTH−1 to 0, in either lock state; wraps modulo 2^CYC_W.
- err_cnt increments on each seq_err; saturates at 255.

Decomposition:
- Shared package johnson_pkg holds:
  - lock_state_e enum (UNLOCKED, LOCKED).
  - Function phase_width(WIDTH).
  - Constant ERR_MAX = 8'hFF.
- One combinational sub-module, johnson_code_check: input WIDTH code; outputs legal and phase.
- Top level holds the prev registers, FSM and counters.

Test Plan:
- Reset: hold rst for 2 cycles with arbitrary inputs → all outputs 0 the cycle after rst drops; locked=0.
- Clean run, WIDTH=8: drive 0x00, 0x01, 0x03 … 0xFF, 0xFE … 0x80, 0x00, one per cycle.
  - phase follows 0..15 then 0 with one-cycle latency.
  - locked rises the cycle after the 4th advance.
  - wrap_cnt=1 after the 0x80→0x00 step; seq_err never asserts.
- Stall: repeat 0x07 for 5 cycles while locked → phase=3 throughout, locked stays 1, no seq_err, match counter unchanged.
- Illegal code: inject 0x05 while locked.
  - legal=0, phase=0, seq_err pulses once, locked=0, err_cnt increments by 1.
  - Next 0x0F: no seq_err; it becomes the new first sample.
- Skipped phase: 0x03 then 0x0F → seq_err pulse, err_cnt+1, FSM returns to UNLOCKED.
- Saturation and reset mid-stream:
  - 300 alternating illegal samples → err_cnt=255 and stays there.
  - Assert rst mid-stream → err_cnt=0, wrap_cnt=0 the next cycle.
